// File: rtl/elevator_scan_controller_pkg.sv
// Shared state encoding and pending-mask helpers for the SCAN elevator controller.
package elevator_pkg;

  localparam int MAX_FLOORS = 16;

  typedef enum logic [1:0] {
    IDLE      = 2'b00,
    DOOR_OPEN = 2'b01,
    MOVE_UP   = 2'b10,
    MOVE_DOWN = 2'b11
  } state_t;

  // Floors strictly above 'floor' that exist in an n-floor building.
  function automatic logic [MAX_FLOORS-1:0] above_mask(input int n, input int floor);
    logic [MAX_FLOORS-1:0] m;
    for (int i = 0; i < MAX_FLOORS; i++) m[i] = (i < n) && (i > floor);
    return m;
  endfunction

  function automatic logic [MAX_FLOORS-1:0] below_mask(input int n, input int floor);
    logic [MAX_FLOORS-1:0] m;
    for (int i = 0; i < MAX_FLOORS; i++) m[i] = (i < n) && (i < floor);
    return m;
  endfunction

endpackage

// File: rtl/elevator_scan_controller_if.sv
// Floor call request bus from the ui_in decode into the controller.
interface elevator_scan_controller_if #(parameter int FLOOR_W = 4);
  logic               req_valid;
  logic [FLOOR_W-1:0] req_floor;

  modport master (output req_valid, output req_floor);
  modport slave  (input  req_valid, input  req_floor);
endinterface

// File: rtl/elevator_scan_controller_timer.sv
// Shared up-counter; done pulses on the last cycle before terminal and the count wraps to 0.
module elevator_timer #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             enable,
  input  logic [CNT_W-1:0] term,
  output logic             done
);

  logic [CNT_W-1:0] cnt;

  assign done = enable && !clear && (cnt == term - CNT_W'(1));

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n)           cnt <= '0;
    else if (clear)      cnt <= '0;
    else if (done)       cnt <= '0;
    else if (enable)     cnt <= cnt + CNT_W'(1);
  end

endmodule

// File: rtl/elevator_scan_controller.sv
// SCAN-ordered elevator controller: latches calls, times floor travel and door dwell.
module elevator_scan_controller
  import elevator_pkg::*;
#(
  parameter int NUM_FLOORS   = 8,
  parameter int FLOOR_W      = 4,
  parameter int TRAVEL_TICKS = 10_000_000,
  parameter int DOOR_TICKS   = 20_000_000,
  parameter int CNT_W        = 32
) (
  input  logic                      clk,
  input  logic                      rst_n,
  elevator_scan_controller_if.slave req,
  output logic [FLOOR_W-1:0]        current_floor,
  output logic                      dir_up,
  output logic                      moving,
  output logic                      door_open,
  output logic                      idle,
  output logic [NUM_FLOORS-1:0]     pending
);

  state_t                state, state_nxt;
  logic [FLOOR_W-1:0]    floor_nxt, nf;
  logic                  dir_nxt;
  logic [NUM_FLOORS-1:0] pending_nxt, req_bits, clr_bits, cur_bit, nf_bit;
  logic [MAX_FLOORS-1:0] am_c, bm_c, am_n, bm_n;
  logic                  req_ok, req_here, stationary;
  logic                  above, below, above_n, below_n, here_pend, nf_pend, ahead_n, behind_n;
  logic                  tmr_clear, tmr_en, tmr_done;
  logic [CNT_W-1:0]      tmr_term;

  assign stationary = (state == IDLE) || (state == DOOR_OPEN);
  assign req_ok     = req.req_valid && (32'(req.req_floor) < NUM_FLOORS);
  assign req_here   = req_ok && (req.req_floor == current_floor);
  assign nf         = (state == MOVE_DOWN) ? current_floor - FLOOR_W'(1)
                                           : current_floor + FLOOR_W'(1);

  always_comb begin
    for (int i = 0; i < NUM_FLOORS; i++) begin
      req_bits[i] = req_ok && (32'(req.req_floor) == i) && !(stationary && req_here);
      cur_bit[i]  = (32'(current_floor) == i);
      nf_bit[i]   = (32'(nf) == i);
    end
  end

  assign am_c = above_mask(NUM_FLOORS, 32'(current_floor));
  assign bm_c = below_mask(NUM_FLOORS, 32'(current_floor));
  assign am_n = above_mask(NUM_FLOORS, 32'(nf));
  assign bm_n = below_mask(NUM_FLOORS, 32'(nf));

  assign above     = |(pending & am_c[NUM_FLOORS-1:0]);
  assign below     = |(pending & bm_c[NUM_FLOORS-1:0]);
  assign above_n   = |(pending & am_n[NUM_FLOORS-1:0]);
  assign below_n   = |(pending & bm_n[NUM_FLOORS-1:0]);
  assign here_pend = |(pending & cur_bit);
  assign nf_pend   = |(pending & nf_bit);
  assign ahead_n   = (state == MOVE_UP) ? above_n : below_n;
  assign behind_n  = (state == MOVE_UP) ? below_n : above_n;
  assign tmr_term  = (state == MOVE_UP || state == MOVE_DOWN) ? CNT_W'(TRAVEL_TICKS)
                                                              : CNT_W'(DOOR_TICKS);

  always_comb begin
    state_nxt = state;
    floor_nxt = current_floor;
    dir_nxt   = dir_up;
    clr_bits  = '0;
    tmr_clear = 1'b0;
    tmr_en    = 1'b0;
    case (state)
      IDLE: begin
        tmr_clear = 1'b1;
        if (here_pend || req_here) begin
          state_nxt = DOOR_OPEN;
          clr_bits  = cur_bit;
        end else if (above && (dir_up || !below)) begin
          state_nxt = MOVE_UP;
          dir_nxt   = 1'b1;
        end else if (below) begin
          state_nxt = MOVE_DOWN;
          dir_nxt   = 1'b0;
        end
      end
      MOVE_UP, MOVE_DOWN: begin
        tmr_en = 1'b1;
        if (tmr_done) begin
          floor_nxt = nf;
          if (nf_pend) begin
            state_nxt = DOOR_OPEN;
            clr_bits  = nf_bit;
          end else if (!ahead_n) begin
            if (behind_n) begin
              state_nxt = (state == MOVE_UP) ? MOVE_DOWN : MOVE_UP;
              dir_nxt   = (state == MOVE_DOWN);
            end else begin
              state_nxt = IDLE;
            end
          end
        end
      end
      DOOR_OPEN: begin
        tmr_en    = 1'b1;
        tmr_clear = req_here;
        if (tmr_done) begin
          if (above && (dir_up || !below)) begin
            state_nxt = MOVE_UP;
            dir_nxt   = 1'b1;
          end else if (below) begin
            state_nxt = MOVE_DOWN;
            dir_nxt   = 1'b0;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Clear wins over a simultaneous set of the same bit: the car is already there.
  assign pending_nxt = (pending | req_bits) & ~clr_bits;

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state         <= IDLE;
      current_floor <= '0;
      dir_up        <= 1'b1;
      pending       <= '0;
    end else begin
      state         <= state_nxt;
      current_floor <= floor_nxt;
      dir_up        <= dir_nxt;
      pending       <= pending_nxt;
    end
  end

  assign idle      = (state == IDLE);
  assign moving    = (state == MOVE_UP) || (state == MOVE_DOWN);
  assign door_open = (state == DOOR_OPEN);

  elevator_timer #(.CNT_W(CNT_W)) u_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (tmr_clear),
    .enable (tmr_en),
    .term   (tmr_term),
    .done   (tmr_done)
  );

endmodule

// File: tb/tb_elevator_scan_controller.sv
// Directed bench for the SCAN elevator controller (8 floors, travel 4, dwell 3).
module tb_elevator_scan_controller;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] current_floor;
  logic       dir_up, moving, door_open, idle;
  logic [7:0] pending;

  int n_checks = 0;
  int n_fail   = 0;
  int stops[$];
  int stop_dirs[$];
  logic door_prev = 1'b0;

  elevator_scan_controller_if #(.FLOOR_W(4)) bus ();

  elevator_scan_controller #(
    .NUM_FLOORS(8), .FLOOR_W(4), .TRAVEL_TICKS(4), .DOOR_TICKS(3), .CNT_W(32)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req           (bus),
    .current_floor (current_floor),
    .dir_up        (dir_up),
    .moving        (moving),
    .door_open     (door_open),
    .idle          (idle),
    .pending       (pending)
  );

  always #5 clk = ~clk;

  // Log floor and direction every time the door opens.
  always @(negedge clk) begin
    if (door_open && !door_prev) begin
      stops.push_back(int'(current_floor));
      stop_dirs.push_back(int'(dir_up));
    end
    door_prev = door_open;
  end

  task automatic chk(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int stop_at(input int i);
    return (i < stops.size()) ? stops[i] : -1;
  endfunction

  function automatic int dir_at(input int i);
    return (i < stop_dirs.size()) ? stop_dirs[i] : -1;
  endfunction

  task automatic send_req(input int f);
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_floor = 4'(f);
    @(negedge clk);
    bus.req_valid = 1'b0;
  endtask

  task automatic wait_floor(input string tag, input int f);
    int n = 0;
    while (int'(current_floor) != f && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk(tag, int'(current_floor), f);
  endtask

  task automatic settle(input string tag);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(idle && pending == 8'h00 && !bus.req_valid) && n < 2000);
    chk(tag, int'(n < 2000), 1);
  endtask

  initial begin
    int cnt;
    int exp_all[8] = '{4, 5, 6, 7, 3, 2, 1, 0};
    int order[8]   = '{4, 5, 6, 7, 0, 1, 2, 3};

    rst_n = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_floor = 4'd0;
    repeat (3) @(negedge clk);
    chk("rst_idle", int'(idle), 1);
    chk("rst_moving", int'(moving), 0);
    chk("rst_door", int'(door_open), 0);
    chk("rst_floor", int'(current_floor), 0);
    chk("rst_dir", int'(dir_up), 1);
    chk("rst_pending", int'(pending), 0);
    rst_n = 1'b0;

    // Single call 0 -> 5: latency 1 + 1 + 5*4 from the request cycle.
    send_req(5);
    chk("t1_pending", int'(pending), 'h20);
    chk("t1_still_idle", int'(idle), 1);
    cnt = 0;
    do begin
      @(negedge clk);
      cnt++;
    end while (!door_open && cnt < 200);
    chk("t1_latency", cnt, 21);
    chk("t1_floor", int'(current_floor), 5);
    chk("t1_dir", int'(dir_up), 1);
    cnt = 0;
    while (door_open && cnt < 20) begin
      cnt++;
      @(negedge clk);
    end
    chk("t1_dwell", cnt, 3);
    chk("t1_idle", int'(idle), 1);
    chk("t1_pending_clr", int'(pending), 0);

    // Out-of-range floor numbers are dropped.
    send_req(9);
    chk("inv9_pending", int'(pending), 0);
    chk("inv9_idle", int'(idle), 1);
    send_req(15);
    chk("inv15_pending", int'(pending), 0);
    @(negedge clk);
    chk("inv15_idle", int'(idle), 1);
    chk("inv_floor", int'(current_floor), 5);

    // Same-floor call opens the door immediately; a repeat extends the dwell.
    send_req(5);
    chk("same_door", int'(door_open), 1);
    chk("same_pending", int'(pending), 0);
    @(negedge clk);
    send_req(5);
    chk("ext_pending", int'(pending), 0);
    cnt = 0;
    while (door_open && cnt < 20) begin
      cnt++;
      @(negedge clk);
    end
    chk("ext_dwell", cnt, 3);

    // Double call to the top floor: one stop, no overrun.
    stops.delete(); stop_dirs.delete();
    send_req(7);
    send_req(7);
    settle("t7_settle");
    chk("t7_nstops", stops.size(), 1);
    chk("t7_stop0", stop_at(0), 7);
    repeat (5) @(negedge clk);
    chk("t7_floor", int'(current_floor), 7);

    // Asynchronous reset in the middle of the 2 -> 3 step.
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk); rst_n = 1'b0;
    chk("rst2_floor", int'(current_floor), 0);
    send_req(5);
    wait_floor("rst_wait2", 2);
    @(negedge clk);
    chk("rst_mid_moving_before", int'(moving), 1);
    #1 rst_n = 1'b1;
    #1;
    chk("arst_moving", int'(moving), 0);
    chk("arst_floor", int'(current_floor), 0);
    chk("arst_pending", int'(pending), 0);
    chk("arst_idle", int'(idle), 1);
    @(negedge clk); rst_n = 1'b0;

    // Reversal: heading for 6, call 1 arrives at floor 3 and is served on the way back.
    stops.delete(); stop_dirs.delete();
    send_req(6);
    wait_floor("rev_wait3", 3);
    chk("rev_moving", int'(moving), 1);
    send_req(6);
    send_req(1);
    settle("rev_settle");
    chk("rev_nstops", stops.size(), 2);
    chk("rev_stop0", stop_at(0), 6);
    chk("rev_stop1", stop_at(1), 1);
    chk("rev_dir0", dir_at(0), 1);
    chk("rev_dir1", dir_at(1), 0);
    chk("rev_floor", int'(current_floor), 1);

    // Park at 4 going up, then strobe every floor on consecutive cycles.
    send_req(4);
    settle("all_park");
    chk("all_park_floor", int'(current_floor), 4);
    chk("all_park_dir", int'(dir_up), 1);
    stops.delete(); stop_dirs.delete();
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      bus.req_valid = 1'b1;
      bus.req_floor = 4'(order[i]);
    end
    @(negedge clk);
    bus.req_valid = 1'b0;
    settle("all_settle");
    chk("all_nstops", stops.size(), 8);
    for (int i = 0; i < 8; i++)
      chk($sformatf("all_stop%0d", i), stop_at(i), exp_all[i]);
    chk("all_floor", int'(current_floor), 0);
    chk("all_idle", int'(idle), 1);
    chk("all_dir", int'(dir_up), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
